// File: rtl/definitions_pkg.sv
// Shared RV32I types for the multicycle core.
// Opcodes, instruction fields, ALU ops and controller enums.
package definitions_pkg;

    localparam int F7_ALT_BIT = 5;

    typedef enum logic [6:0] {
        OP_LOAD    = 7'b0000011,
        OP_S       = 7'b0100011,
        OP_I_ALU   = 7'b0010011,
        OP_R       = 7'b0110011,
        OP_B       = 7'b1100011,
        OP_J_JAL   = 7'b1101111,
        OP_I_JALR  = 7'b1100111,
        OP_U_LUI   = 7'b0110111,
        OP_U_AUIPC = 7'b0010111,
        OP_I_ECALL = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_e;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JALR,
        S_JAL, S_LUI, S_AUIPC, S_HALT, S_TRAP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_MEM    = 2'b01,
        RES_ALU    = 2'b10,
        RES_IMM    = 2'b11
    } result_src_e;

endpackage

// File: rtl/rv32i_alu_decoder.sv
// ALU operation decode for R and I_ALU instructions.
// SUB only for R-type; funct7 alt bit picks SRA.
module rv32i_alu_decoder
    import definitions_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_alt,
    output alu_e       alu_op
);

    logic is_r;
    assign is_r = (opcode == OP_R);

    // Map funct3 to the ALU function
    always_comb begin
        alu_op = ALU_ADD;
        unique case (funct3)
            3'b000: alu_op = (is_r && funct7_alt) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = funct7_alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            3'b111: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_controller.sv
// Multicycle control FSM for the RV32I datapath.
// Sequences fetch/decode/execute/mem/writeback; counts retires.
module rv32i_mc_controller
    import definitions_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  instruction_t         instr,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 reg_we,
    output alu_src_a_e           alu_src_a,
    output alu_src_b_e           alu_src_b,
    output result_src_e          result_src,
    output alu_e                 alu_op,
    output imm_src_e             imm_src,
    output logic                 halt,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    ctrl_state_e state;
    ctrl_state_e next;
    alu_e        dec_op;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        bad_f3;
    logic        taken;

    assign op = instr.opcode;
    assign f3 = instr.funct3;

    rv32i_alu_decoder u_alu_dec (
        .opcode     (op),
        .funct3     (f3),
        .funct7_alt (instr.funct7[F7_ALT_BIT]),
        .alu_op     (dec_op)
    );

    // Reject funct3 encodings with no defined meaning
    always_comb begin
        bad_f3 = 1'b0;
        case (op)
            OP_LOAD:   bad_f3 = (f3 == 3'b011) || (f3 >= 3'b110);
            OP_S:      bad_f3 = (f3 >= 3'b011);
            OP_B:      bad_f3 = (f3 == 3'b010) || (f3 == 3'b011);
            OP_I_JALR: bad_f3 = (f3 != 3'b000);
            default:   bad_f3 = 1'b0;
        endcase
    end

    // Branch condition from the datapath comparison flags
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:   next = S_FETCH;
            S_FETCH:  if (mem_ready) next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_S: next = S_MEMADR;
                    OP_I_ALU:      next = S_EXEC_I;
                    OP_R:          next = S_EXEC_R;
                    OP_B:          next = S_BRANCH;
                    OP_J_JAL:      next = S_JAL;
                    OP_I_JALR:     next = S_JALR;
                    OP_U_LUI:      next = S_LUI;
                    OP_U_AUIPC:    next = S_AUIPC;
                    OP_I_ECALL:    next = S_HALT;
                    default:       next = S_TRAP;
                endcase
                if (bad_f3) next = S_TRAP;
            end
            S_MEMADR: begin
                if (op == OP_LOAD) next = S_MEMRD;
                else               next = S_MEMWR;
            end
            S_MEMRD:  if (mem_ready) next = S_MEMWB;
            S_MEMWB:  next = S_FETCH;
            S_MEMWR:  if (mem_ready) next = S_FETCH;
            S_EXEC_R: next = S_ALUWB;
            S_EXEC_I: next = S_ALUWB;
            S_ALUWB:  next = S_FETCH;
            S_BRANCH: next = S_FETCH;
            S_JALR:   next = S_JAL;
            S_JAL:    next = S_ALUWB;
            S_LUI:    next = S_FETCH;
            S_AUIPC:  next = S_ALUWB;
            S_HALT:   next = S_HALT;
            S_TRAP:   next = S_TRAP;
            default:  next = S_IDLE;
        endcase
    end

    // State register and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            instret <= '0;
        end else begin
            state <= next;
            if (next == S_FETCH && state != S_IDLE
                && state != S_FETCH)
                instret <= instret + INSTRET_W'(1);
        end
    end

    // Moore output decode, with ready/flag gating
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALU_ADD;
        imm_src    = IMM_I;
        halt       = 1'b0;
        illegal    = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_we      = mem_ready;
                pc_we      = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                if (op == OP_J_JAL) imm_src = IMM_J;
                else                imm_src = IMM_B;
            end
            S_MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                if (op == OP_LOAD) imm_src = IMM_I;
                else               imm_src = IMM_S;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_we     = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = dec_op;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = dec_op;
            end
            S_ALUWB: reg_we = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_SUB;
                pc_we     = taken;
            end
            S_JALR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_we     = 1'b1;
            end
            S_LUI: begin
                imm_src    = IMM_U;
                result_src = RES_IMM;
                reg_we     = 1'b1;
            end
            S_AUIPC: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = IMM_U;
            end
            S_HALT:  halt    = 1'b1;
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Self-checking bench for rv32i_mc_controller.
// Expected cycle counts and retire counts go through a queue.
module tb_rv32i_mc_controller;
    import definitions_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    instruction_t instr = '0;
    logic         alu_zero = 1'b0;
    logic         alu_lt = 1'b0;
    logic         alu_ltu = 1'b0;
    logic         mem_ready = 1'b0;
    logic         mem_req, mem_we, adr_src;
    logic         ir_we, pc_we, reg_we;
    alu_src_a_e   alu_src_a;
    alu_src_b_e   alu_src_b;
    result_src_e  result_src;
    alu_e         alu_op;
    imm_src_e     imm_src;
    logic         halt, illegal;
    logic [31:0]  instret;

    rv32i_mc_controller #(.INSTRET_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .adr_src(adr_src), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .imm_src(imm_src),
        .halt(halt), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem_req, mem_we, adr_src, ir_we, pc_we, reg_we;
        logic        halt, illegal;
        result_src_e rs;
        alu_e        op;
        imm_src_e    imm;
    } snap_t;

    typedef struct {
        int          cycles;
        logic [31:0] ret;
    } exp_t;

    snap_t       snap [40];
    exp_t        exp_q [$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          cyc;
    logic [31:0] obs_ret;
    logic [31:0] model_ret = 0;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_ret = 0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int st,
                             input int sn, input int max_c,
                             output int cy);
        cy = -1;
        for (int c = 0; c < max_c; c++) begin
            @(negedge clk);
            instr = ins;
            mem_ready = !(c >= st && c < st + sn);
            #1;
            if (c > 0 && mem_req && !adr_src) begin
                mem_ready = 1'b0;
                cy = c;
                break;
            end
            snap[c] = '{mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
                        halt, illegal, result_src, alu_op, imm_src};
        end
        obs_ret = instret;
    endtask

    task automatic push_exp(input int cy, input logic retire);
        if (retire) model_ret = model_ret + 1;
        exp_q.push_back('{cy, model_ret});
    endtask

    task automatic check_exp(input string nm);
        e = exp_q.pop_front();
        total++;
        if (cyc !== e.cycles) begin
            bad++;
            $display("FAIL %s cycles got=%0d want=%0d", nm, cyc, e.cycles);
        end
        total++;
        if (obs_ret !== e.ret) begin
            bad++;
            $display("FAIL %s instret got=%0d want=%0d", nm, obs_ret, e.ret);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if ({mem_req, mem_we, adr_src, ir_we, pc_we, reg_we, halt, illegal}
            !== 8'h00 || alu_op !== ALU_ADD || imm_src !== IMM_I) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {mem_req, mem_we, pc_we, reg_we});
        end
        total++;
        if (instret !== 32'd0) begin
            bad++;
            $display("FAIL reset_instret got=%0d want=0", instret);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_req got=%b want=0", mem_req);
        end
        @(negedge clk);
        #1;
        total++;
        if (mem_req !== 1'b1 || adr_src !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_fetch got=%b want=1", mem_req);
        end
        model_ret = 0;
    endtask

    task automatic test_addi();
        push_exp(4, 1'b1);
        run_instr(32'h00500513, 99, 0, 40, cyc);
        check_exp("addi");
        total++;
        if (snap[0].ir_we !== 1'b1 || snap[0].pc_we !== 1'b1
            || snap[0].rs !== RES_ALU) begin
            bad++;
            $display("FAIL addi_fetch got=%b%b want=11",
                     snap[0].ir_we, snap[0].pc_we);
        end
        total++;
        if (snap[3].reg_we !== 1'b1 || snap[3].rs !== RES_ALUOUT) begin
            bad++;
            $display("FAIL addi_wb got=%b/%0d want=1/0",
                     snap[3].reg_we, snap[3].rs);
        end
        total++;
        if (snap[1].reg_we !== 1'b0 || snap[2].reg_we !== 1'b0) begin
            bad++;
            $display("FAIL addi_early_we got=%b%b want=00",
                     snap[1].reg_we, snap[2].reg_we);
        end
    endtask

    task automatic test_alu_decode();
        logic [31:0] ins [4];
        alu_e        want [4];
        ins  = '{32'h403100B3, 32'h40315093, 32'h00315093, 32'h40010093};
        want = '{ALU_SUB, ALU_SRA, ALU_SRL, ALU_ADD};
        for (int i = 0; i < 4; i++) begin
            push_exp(4, 1'b1);
            run_instr(ins[i], 99, 0, 40, cyc);
            check_exp("alu_dec");
            total++;
            if (snap[2].op !== want[i]) begin
                bad++;
                $display("FAIL alu_dec_%0d op got=%0d want=%0d",
                         i, snap[2].op, want[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4];
        logic [2:0]  flg [4];
        logic        want [4];
        ins  = '{32'h00208063, 32'h00208063, 32'h0020E063, 32'h0020D063};
        flg  = '{3'b100, 3'b000, 3'b001, 3'b010};
        want = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            {alu_zero, alu_lt, alu_ltu} = flg[i];
            push_exp(3, 1'b1);
            run_instr(ins[i], 99, 0, 40, cyc);
            check_exp("branch");
            total++;
            if (snap[2].pc_we !== want[i] || snap[2].op !== ALU_SUB) begin
                bad++;
                $display("FAIL branch_%0d pc_we got=%b want=%b",
                         i, snap[2].pc_we, want[i]);
            end
        end
        {alu_zero, alu_lt, alu_ltu} = 3'b000;
    endtask

    task automatic test_load_stall();
        push_exp(8, 1'b1);
        run_instr(32'h00012083, 3, 3, 40, cyc);
        check_exp("lw_stall");
        for (int c = 3; c < 7; c++) begin
            total++;
            if (snap[c].mem_req !== 1'b1 || snap[c].adr_src !== 1'b1
                || snap[c].reg_we !== 1'b0) begin
                bad++;
                $display("FAIL lw_hold_%0d got=%b%b want=11",
                         c, snap[c].mem_req, snap[c].adr_src);
            end
        end
        total++;
        if (snap[7].reg_we !== 1'b1 || snap[7].rs !== RES_MEM) begin
            bad++;
            $display("FAIL lw_wb got=%b/%0d want=1/1",
                     snap[7].reg_we, snap[7].rs);
        end
    endtask

    task automatic test_store();
        push_exp(4, 1'b1);
        run_instr(32'h00112023, 99, 0, 40, cyc);
        check_exp("sw");
        total++;
        if (snap[3].mem_we !== 1'b1 || snap[2].imm !== IMM_S
            || snap[3].reg_we !== 1'b0) begin
            bad++;
            $display("FAIL sw_write we=%b imm=%0d want=1/1",
                     snap[3].mem_we, snap[2].imm);
        end
    endtask

    task automatic test_back_to_back();
        push_exp(3, 1'b1);
        push_exp(4, 1'b1);
        push_exp(5, 1'b1);
        push_exp(4, 1'b1);
        run_instr(32'h123450B7, 99, 0, 40, cyc);
        check_exp("lui");
        total++;
        if (snap[2].reg_we !== 1'b1 || snap[2].rs !== RES_IMM
            || snap[2].imm !== IMM_U) begin
            bad++;
            $display("FAIL lui_wb got=%b/%0d want=1/3",
                     snap[2].reg_we, snap[2].rs);
        end
        run_instr(32'h000000EF, 99, 0, 40, cyc);
        check_exp("jal");
        total++;
        if (snap[2].pc_we !== 1'b1 || snap[3].reg_we !== 1'b1
            || snap[1].imm !== IMM_J) begin
            bad++;
            $display("FAIL jal_flow got=%b%b want=11",
                     snap[2].pc_we, snap[3].reg_we);
        end
        run_instr(32'h000100E7, 99, 0, 40, cyc);
        check_exp("jalr");
        total++;
        if (snap[3].pc_we !== 1'b1 || snap[4].reg_we !== 1'b1) begin
            bad++;
            $display("FAIL jalr_flow got=%b%b want=11",
                     snap[3].pc_we, snap[4].reg_we);
        end
        run_instr(32'h00001097, 99, 0, 40, cyc);
        check_exp("auipc");
    endtask

    task automatic test_terminal();
        logic [31:0] ins [3];
        ins = '{32'h0000007F, 32'h00013083, 32'h00000073};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            push_exp(4, 1'b1);
            run_instr(32'h00500513, 99, 0, 40, cyc);
            check_exp("pre_term");
            push_exp(-1, 1'b0);
            run_instr(ins[i], 99, 0, 8, cyc);
            check_exp("term");
            total++;
            if (i < 2 && (snap[2].illegal !== 1'b1
                || snap[7].illegal !== 1'b1 || snap[7].halt !== 1'b0)) begin
                bad++;
                $display("FAIL trap_%0d illegal got=%b want=1",
                         i, snap[7].illegal);
            end
            total++;
            if (i == 2 && (snap[2].halt !== 1'b1
                || snap[7].halt !== 1'b1 || snap[7].illegal !== 1'b0)) begin
                bad++;
                $display("FAIL ecall halt got=%b want=1", snap[7].halt);
            end
            total++;
            if (snap[7].mem_req !== 1'b0) begin
                bad++;
                $display("FAIL term_%0d mem_req got=%b want=0",
                         i, snap[7].mem_req);
            end
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        push_exp(4, 1'b1);
        run_instr(32'h00500513, 99, 0, 40, cyc);
        check_exp("pre_rst");
        run_instr(32'h00112023, 3, 99, 4, cyc);
        total++;
        if (snap[3].mem_we !== 1'b1 || snap[3].mem_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre we got=%b want=1", snap[3].mem_we);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_we, adr_src, reg_we, pc_we} !== 5'b0) begin
            bad++;
            $display("FAIL rst_mid_out got=%b want=0",
                     {mem_req, mem_we, adr_src, reg_we, pc_we});
        end
        total++;
        if (instret !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_instret got=%0d want=0", instret);
        end
        @(posedge clk);
        #1;
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_hold we got=%b want=0", mem_we);
        end
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_alu_decode();
        test_branch();
        test_load_stall();
        test_store();
        test_back_to_back();
        test_terminal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
